// File: rtl/sram8t_pkg.sv
// Shared types and sizing helpers for the 8T SRAM access controller.
package sram8t_pkg;

  typedef enum logic [2:0] {IDLE, PRE, GUARD, ACCESS, DONE} state_e;

  // Phase counter must hold max(PRE_CYC, WL_CYC)-1; never narrower than 1 bit.
  function automatic int cnt_w(input int pre_cyc, input int wl_cyc);
    int m;
    m = (pre_cyc > wl_cyc) ? pre_cyc : wl_cyc;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sram8t_row_dec.sv
// Registered one-hot row decoder; output is all-zero whenever en_i is low.
module sram8t_row_dec #(
  parameter int ROWS = 16,
  parameter int AW   = $clog2(ROWS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   addr_i,
  input  logic            en_i,
  output logic [ROWS-1:0] wl_o
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wl_o <= '0;
    end else begin
      for (int r = 0; r < ROWS; r++) wl_o[r] <= en_i && (addr_i == AW'(r));
    end
  end

endmodule

// File: rtl/sram8t_access_ctrl.sv
// Sequences single-word accesses to an 8T array: precharge, guard, word-line pulse, response.
module sram8t_access_ctrl
  import sram8t_pkg::*;
#(
  parameter int ROWS    = 16,
  parameter int COLS    = 8,
  parameter int PRE_CYC = 1,
  parameter int WL_CYC  = 2,
  parameter int AW      = $clog2(ROWS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [AW-1:0]   req_addr,
  input  logic [COLS-1:0] req_wdata,
  output logic            rsp_valid,
  output logic            rsp_err,
  output logic [COLS-1:0] rsp_rdata,
  output logic            busy,
  output logic            pre_n,
  output logic [ROWS-1:0] wwl,
  output logic [ROWS-1:0] rwl,
  output logic            wbl_en,
  output logic [COLS-1:0] wbl,
  output logic [COLS-1:0] wblb,
  input  logic [COLS-1:0] rbl
);

  localparam int CW = cnt_w(PRE_CYC, WL_CYC);

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic            we_q;
  logic [AW-1:0]   addr_q;
  logic [COLS-1:0] wdata_q;
  logic            ready_q, busy_q, pre_n_q, wbl_en_q;
  logic [COLS-1:0] wbl_q, wblb_q;
  logic            rsp_valid_q, rsp_err_q;
  logic [COLS-1:0] rsp_rdata_q;
  logic            addr_ok, wl_on_d;

  assign addr_ok = 32'(req_addr) < ROWS;
  // Word lines are registered in the decoders, so enable them one cycle ahead.
  assign wl_on_d = (state_q == GUARD) || (state_q == ACCESS && cnt_q != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      pre_n_q     <= 1'b0;
      wbl_en_q    <= 1'b0;
      wbl_q       <= '0;
      wblb_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (req_valid && ready_q) begin
          we_q    <= req_we;
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          ready_q <= 1'b0;
          busy_q  <= 1'b1;
          if (addr_ok) begin
            state_q <= PRE;
            cnt_q   <= CW'(PRE_CYC - 1);
          end else begin
            // Out-of-range: one dwell cycle in DONE before the response strobe.
            state_q <= DONE;
            cnt_q   <= CW'(1);
          end
        end
        PRE: begin
          if (cnt_q == '0) begin
            state_q  <= GUARD;
            pre_n_q  <= 1'b1;
            wbl_en_q <= we_q;
            wbl_q    <= we_q ? wdata_q : '0;
            wblb_q   <= we_q ? ~wdata_q : '0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        GUARD: begin
          state_q <= ACCESS;
          cnt_q   <= CW'(WL_CYC - 1);
        end
        ACCESS: begin
          if (cnt_q == '0) begin
            state_q     <= DONE;
            pre_n_q     <= 1'b0;
            wbl_en_q    <= 1'b0;
            wbl_q       <= '0;
            wblb_q      <= '0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= we_q ? '0 : ~rbl;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          if (cnt_q != '0) begin
            cnt_q       <= '0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
          end else begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  sram8t_row_dec #(.ROWS(ROWS), .AW(AW)) u_wdec (
    .clk(clk), .rst_n(rst_n), .addr_i(addr_q), .en_i(wl_on_d && we_q), .wl_o(wwl)
  );

  sram8t_row_dec #(.ROWS(ROWS), .AW(AW)) u_rdec (
    .clk(clk), .rst_n(rst_n), .addr_i(addr_q), .en_i(wl_on_d && !we_q), .wl_o(rwl)
  );

  assign req_ready = ready_q;
  assign busy      = busy_q;
  assign pre_n     = pre_n_q;
  assign wbl_en    = wbl_en_q;
  assign wbl       = wbl_q;
  assign wblb      = wblb_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule
